// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helper for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } kx_state_e;

    localparam int NR_128 = 10;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 8-bit to 8-bit lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0 occupies the top byte, so the entry for 'a' starts at bit (255-a)*8 = {~a,3'b0}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TBL[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key-expansion sequencer: writes round keys 0..NR into the
// split round-key RAM, one round key per cycle, then flags key_valid.
//
// Handshake: start is a single-cycle request sampled only in IDLE; wr is the
// sole qualifier of wr_addr/wr_data_*, which otherwise hold their last value.
module aes_key_expand_128
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic         wr,
    output logic [3:0]   wr_addr,
    output logic [63:0]  wr_data_hi,
    output logic [63:0]  wr_data_lo,
    output logic [1:0]   dbg_state
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    kx_state_e   state, state_next;
    rkey_t       rk, rk_next;
    logic [3:0]  round;
    logic [7:0]  rcon;
    logic        load, step;

    word_t w0, w1, w2, w3;
    word_t rot_w3, sub_w3, t;
    word_t n0, n1, n2, n3;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_w3[i*8 +: 8]),
            .y (sub_w3[i*8 +: 8])
        );
    end

    assign t  = sub_w3 ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode; the last WRITE cycle leaves rk/round untouched.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (round == LAST_ROUND) state_next = DONE;
                else                     step       = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Round-key datapath, round counter, xtime rcon generator and key_valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk        <= '0;
            round     <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
        end else begin
            if (load) begin
                rk        <= key_in;
                round     <= '0;
                rcon      <= 8'h01;
                key_valid <= 1'b0;
            end else if (step) begin
                rk    <= rk_next;
                round <= round + 4'd1;
                rcon  <= xtime(rcon);
            end
            if (state == DONE) key_valid <= 1'b1;
        end
    end

    assign wr         = (state == WRITE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign wr_addr    = round;
    assign wr_data_hi = rk[127:64];
    assign wr_data_lo = rk[63:0];
    assign dbg_state  = state;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Bench for aes_key_expand_128: scoreboard of expected RAM writes from an
// independent key-schedule model (S-box derived from GF(2^8) inverse + affine map).
module tb_aes_key_expand_128;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, key_valid, wr;
    logic [3:0]   wr_addr;
    logic [63:0]  wr_data_hi, wr_data_lo;
    logic [1:0]   dbg_state;

    aes_key_expand_128 #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .key_valid  (key_valid),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_data_hi (wr_data_hi),
        .wr_data_lo (wr_data_lo),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    logic [131:0] exp_q[$];
    logic [127:0] wr_log [0:15];
    logic [7:0]   tb_sbox [0:255];
    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        tmp = {w[3][23:0], w[3][31:24]};
        tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        w[0] = w[0] ^ tmp;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic push_model(input logic [127:0] key);
        logic [127:0] k = key;
        for (int r = 0; r <= 10; r++) begin
            exp_q.push_back({4'(r), k});
            if (r < 10) k = model_next(k, rcon_tab[r]);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && wr) begin
            n_wr++;
            wr_log[wr_addr] = {wr_data_hi, wr_data_lo};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr %0d data %h, expected no write",
                         wr_addr, {wr_data_hi, wr_data_lo});
            end else begin
                check("wr_data", {wr_addr, wr_data_hi, wr_data_lo}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge of cycle 1 after the accepting edge.
    task automatic issue(input logic [127:0] key);
        @(negedge clk);
        n_wr   = 0;
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, done, 1'b1);
        check({name, "_n_wr"}, n_wr, 11);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] k2;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        do_reset();

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_wr", wr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", {wr_data_hi, wr_data_lo}, 0);

        // FIPS-197 A.1 key with cycle-by-cycle timing
        push_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        issue(128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("a1_wr_c%0d", k), wr, k <= 11);
            check($sformatf("a1_busy_c%0d", k), busy, k <= 12);
            check($sformatf("a1_done_c%0d", k), done, k == 12);
            check($sformatf("a1_kv_c%0d", k), key_valid, k >= 13);
            if (k <= 11) check($sformatf("a1_addr_c%0d", k), wr_addr, k - 1);
            @(negedge clk);
        end
        check("a1_n_wr", n_wr, 11);
        check("a1_addr0", wr_log[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("a1_addr1", wr_log[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_addr10", wr_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a1_hold_addr", wr_addr, 10);
        check("a1_hold_data", {wr_data_hi, wr_data_lo}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key
        push_model(128'h0);
        issue(128'h0);
        wait_done("zero");
        check("zero_addr1", wr_log[1],  128'h62636363626363636263636362636363);
        check("zero_addr10", wr_log[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // start re-pulsed mid-expansion is ignored
        push_model(128'h000102030405060708090a0b0c0d0e0f);
        issue(128'h000102030405060708090a0b0c0d0e0f);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        key_in = 128'hffeeddccbbaa99887766554433221100;
        @(negedge clk);
        start  = 1'b0;
        wait_done("restart");
        check("restart_addr0", wr_log[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("restart_addr10", wr_log[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset mid-expansion
        push_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        issue(128'h2b7e151628aed2a6abf7158809cf4f3c);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr", wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_key_valid", key_valid, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        issue(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done("after_rst");
        check("after_rst_addr10", wr_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: start in done cycle ignored, next cycle accepted
        push_model(128'h0);
        issue(128'h0);
        repeat (11) @(negedge clk);
        check("b2b_done", done, 1);
        start  = 1'b1;
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        @(negedge clk);
        check("b2b_kv_set", key_valid, 1);
        check("b2b_idle_wr", wr, 0);
        check("b2b_idle_busy", busy, 0);
        n_wr = 0;
        push_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(negedge clk);
        start = 1'b0;
        check("b2b_kv_clear", key_valid, 0);
        check("b2b_wr", wr, 1);
        check("b2b_addr", wr_addr, 0);
        wait_done("b2b");
        @(negedge clk);
        check("b2b_kv_final", key_valid, 1);

        // Random keys against the reference model
        for (int i = 0; i < 200; i++) begin
            k2 = {$urandom, $urandom, $urandom, $urandom};
            push_model(k2);
            issue(k2);
            wait_done($sformatf("rnd%0d", i));
        end
        repeat (3) @(negedge clk);
        check("final_idle_wr", wr, 0);
        check("final_n_wr", n_wr, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
